// File: rtl/mem_io_responder_pkg.sv
// Shared bus widths, IO address map and request encodings for the
// byte-serial memory/IO responder.
package mem_io_responder_pkg;

    localparam int ADDR_BUS_W = 32;
    localparam int MEM_DATA_W = 8;

    typedef logic [ADDR_BUS_W-1:0] addr_bus_t;
    typedef logic [MEM_DATA_W-1:0] mem_data_t;

    localparam logic [1:0] IO_BASE_HI  = 2'b11;
    localparam int         IO_DATA_OFS = 0;
    localparam int         IO_HALT_OFS = 4;

    typedef enum logic {
        RW_READ  = 1'b0,
        RW_WRITE = 1'b1
    } rw_e;

    // IO register select is address bit 2: DATA at offset 0, HALT at offset 4
    typedef enum logic {
        IO_REG_DATA = 1'b0,
        IO_REG_HALT = 1'b1
    } io_reg_e;

    function automatic logic is_io_addr(input addr_bus_t addr);
        return addr[17:16] == IO_BASE_HI;
    endfunction

endpackage

// File: rtl/mem_io_responder_fifo.sv
// Synchronous byte FIFO with occupancy count; a pop on a full FIFO frees a
// slot for a push in the same cycle, and the head reads as zero when empty.
module sync_byte_fifo
    import mem_io_responder_pkg::*;
#(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [7:0]            din,
    input  logic                  pop,
    output logic [7:0]            dout,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = DEPTH_LOG2 + 1;
    localparam logic [CNT_W-1:0]      DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]      CNT_ONE = CNT_W'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

    mem_data_t             store [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    always_comb begin
        empty   = (count == '0);
        full    = (count == DEPTH_C);
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        dout    = empty ? '0 : store[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            store[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_io_responder.sv
// Byte-wide RAM/IO responder: 1-cycle read latency RAM, UART TX/RX FIFOs and
// a sticky halt register in the 0x30000 window, plus a TX near-full stall.
module mem_io_responder
    import mem_io_responder_pkg::*;
#(
    parameter int RAM_ADDR_W    = 17,
    parameter int TX_DEPTH_LOG2 = 3,
    parameter int RX_DEPTH_LOG2 = 3,
    parameter int FULL_MARGIN   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr,
    input  logic        mem_rw,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic        io_buffer_full,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        halted
);

    localparam int TX_CNT_W = TX_DEPTH_LOG2 + 1;
    localparam int RX_CNT_W = RX_DEPTH_LOG2 + 1;
    localparam logic [TX_CNT_W-1:0] TX_DEPTH_C = TX_CNT_W'(1 << TX_DEPTH_LOG2);
    localparam logic [TX_CNT_W-1:0] MARGIN_C   = TX_CNT_W'(FULL_MARGIN);
    localparam logic [TX_CNT_W-1:0] TX_ONE     = TX_CNT_W'(1);

    mem_data_t             ram [2**RAM_ADDR_W];
    logic [RAM_ADDR_W-1:0] ram_idx;
    logic                  is_io;
    logic                  is_write;
    io_reg_e               io_reg;

    logic                  tx_push_req;
    logic                  tx_push_ok;
    logic                  tx_pop;
    logic                  tx_empty;
    logic                  tx_full;
    logic [TX_CNT_W-1:0]   tx_count;
    logic [TX_CNT_W-1:0]   tx_count_next;
    logic                  tx_overflow;

    logic                  rx_push;
    logic                  rx_pop_req;
    logic [7:0]            rx_head;
    logic                  rx_empty;
    logic                  rx_full;
    logic [RX_CNT_W-1:0]   rx_count;
    logic                  spare_unused;

    always_comb begin
        is_io       = is_io_addr(mem_addr);
        is_write    = (rw_e'(mem_rw) == RW_WRITE);
        io_reg      = io_reg_e'(mem_addr[2]);
        ram_idx     = mem_addr[RAM_ADDR_W-1:0];

        tx_valid    = !tx_empty;
        tx_pop      = tx_valid && tx_ready;
        tx_push_req = is_write && is_io && (io_reg == IO_REG_DATA);
        tx_push_ok  = tx_push_req && (!tx_full || tx_pop);

        rx_ready    = !rx_full;
        rx_push     = rx_valid && rx_ready;
        rx_pop_req  = !is_write && is_io && (io_reg == IO_REG_DATA);
    end

    // Mirrors the FIFO's own accept rule so the stall can be registered
    // against the occupancy the FIFO will hold after this edge.
    always_comb begin
        tx_count_next = tx_count;
        if (tx_push_ok && !tx_pop) begin
            tx_count_next = tx_count + TX_ONE;
        end else if (!tx_push_ok && tx_pop) begin
            tx_count_next = tx_count - TX_ONE;
        end
    end

    sync_byte_fifo #(.DEPTH_LOG2(TX_DEPTH_LOG2)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push_req),
        .din   (mem_din),
        .pop   (tx_pop),
        .dout  (tx_data),
        .empty (tx_empty),
        .full  (tx_full),
        .count (tx_count)
    );

    sync_byte_fifo #(.DEPTH_LOG2(RX_DEPTH_LOG2)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .din   (rx_data),
        .pop   (rx_pop_req),
        .dout  (rx_head),
        .empty (rx_empty),
        .full  (rx_full),
        .count (rx_count)
    );

    always_ff @(posedge clk) begin
        if (!rst && is_write && !is_io) begin
            ram[ram_idx] <= mem_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_dout <= '0;
        end else if (!is_write) begin
            if (!is_io) begin
                mem_dout <= ram[ram_idx];
            end else if (io_reg == IO_REG_HALT) begin
                mem_dout <= {7'b0, halted};
            end else begin
                mem_dout <= rx_empty ? '0 : rx_head;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            halted         <= 1'b0;
            tx_overflow    <= 1'b0;
            io_buffer_full <= 1'b0;
        end else begin
            if (is_write && is_io && (io_reg == IO_REG_HALT)) begin
                halted <= 1'b1;
            end
            if (tx_push_req && !tx_push_ok) begin
                tx_overflow <= 1'b1;
            end
            io_buffer_full <= (TX_DEPTH_C - tx_count_next) <= MARGIN_C;
        end
    end

    // Upper address bits, RX occupancy and the overflow flag have no consumer here.
    assign spare_unused = &{1'b0, mem_addr[31:18], rx_count, tx_overflow};

endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
- Byte-serial memory/IO responder on the far side of the memory-controller RAM port.
- Accepts one byte-wide read or write per cycle, addressed by a 32-bit address and a read/write strobe.
- Low address space maps to an internal synchronous RAM.
- Address window 0x30000+ maps to memory-mapped IO: a UART TX FIFO, a UART RX FIFO and a halt register.
- Generates io_buffer_full, which stalls the controller while the TX FIFO is near capacity.

Parameters:
- RAM_ADDR_W, 17: RAM address width; RAM holds 2^RAM_ADDR_W bytes.
- TX_DEPTH_LOG2, 3: TX FIFO depth = 2^TX_DEPTH_LOG2 bytes.
- RX_DEPTH_LOG2, 3: RX FIFO depth = 2^RX_DEPTH_LOG2 bytes.
- FULL_MARGIN, 2: io_buffer_full asserts when TX free slots <= FULL_MARGIN.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- mem_addr  in  32  byte address from the controller.
- mem_rw  in  1  1 = write, 0 = read.
- mem_din  in  8  write byte from the controller.
- mem_dout  out  8  read byte returned to the controller.
- io_buffer_full  out  1  TX FIFO near-full stall to the controller.
- tx_valid  out  1  TX FIFO head byte available.
- tx_data  out  8  TX FIFO head byte.
- tx_ready  in  1  serial side consumes the head byte when tx_valid && tx_ready.
- rx_valid  in  1  serial side offers a byte.
- rx_data  in  8  offered byte.
- rx_ready  out  1  RX FIFO not full.
- halted  out  1  sticky; set by a write to the halt register.

Behaviour:
- Decode (combinational from mem_addr):
  - is_io = (mem_addr[17:16] == 2'b11).
  - IO register = mem_addr[2]: 0 selects DATA (0x30000), 1 selects HALT (0x30004).
  - RAM index = mem_addr[RAM_ADDR_W-1:0].
  - Upper address bits are ignored.
- RAM write:
  - mem_rw=1 && !is_io: RAM[index] <= mem_din at the clock edge.
  - No read data is produced; mem_dout holds its previous value.
- RAM read:
  - mem_rw=0 && !is_io: mem_dout <= RAM[index] at the edge, so the byte is valid in the cycle after the address is presented.
  - Latency is exactly 1 cycle. A new address every cycle yields back-to-back bytes.
  - Read of a never-written location returns 0x00; the RAM is zero-initialised by the bench/loader.
- IO write to DATA:
  - Pushes mem_din into the TX FIFO.
  - If the TX FIFO is full, the byte is dropped and an overflow flag is set (bench-visible only). The controller must honour io_buffer_full, so this is an error case.
- IO write to HALT: halted <= 1; stays set until rst.
- IO read of DATA:
  - If the RX FIFO is non-empty: mem_dout <= head and the FIFO pops, same 1-cycle latency.
  - If empty: mem_dout <= 0x00, no pop.
- IO read of HALT: mem_dout <= {7'b0, halted}.
- TX FIFO:
  - Pop when tx_valid && tx_ready.
  - tx_valid = count != 0; tx_data = head.
  - Simultaneous push and pop while full: pop frees a slot, push accepted, count unchanged.
  - Simultaneous push and pop while empty: push accepted, no pop, count becomes 1.
- RX FIFO:
  - Push when rx_valid && rx_ready; rx_ready = count != depth.
  - Simultaneous push and pop is legal; count unchanged. A pop on empty with a simultaneous push returns 0x00 and leaves the pushed byte in the FIFO.
- io_buffer_full:
  - Registered: io_buffer_full <= (TX_DEPTH - next_count) <= FULL_MARGIN.
  - The margin absorbs the 1-cycle assertion delay plus one in-flight write.
- Pointers: TX_DEPTH_LOG2 / RX_DEPTH_LOG2 bits, wrap modulo depth; counts are one bit wider.
- Reset (rst=1 at an edge):
  - mem_dout=0, io_buffer_full=0, tx_valid=0, tx_data=0 (head of empty FIFO), rx_ready=1, halted=0.
  - FIFO pointers and counts cleared.
  - RAM contents are NOT cleared.
  - A request present during reset is ignored.
- No internal FSM beyond the FIFOs. The controller owns sequencing; this block is a stateless-per-request responder with 1-cycle read latency.

Decomposition:
- Shared config package/header:
  - AddrBus (32), MemDataBus (8).
  - IO_BASE_HI = 2'b11.
  - IO_DATA_OFS = 0, IO_HALT_OFS = 4.
  - Read/write encoding: Write = 1, Read = 0.
- One sub-module sync_byte_fifo, parameterised by DEPTH_LOG2.
  - Ports: clk, rst, push, din, pop, dout, empty, full, count.
  - Instantiated twice, for TX and RX.

Test Plan:
- RAM round-trip: write 0xAA to 0x00010, 0xBB to 0x00011; read 0x00010 then 0x00011 on consecutive cycles -> mem_dout = 0xAA one cycle after the first read, 0xBB on the next cycle.
- Little-endian word fetch: load 0x13,0x05,0x10,0x00 at 0x0..0x3; four back-to-back reads -> bytes return in order, one per cycle, each with latency 1.
- TX backpressure: tx_ready=0; write 0x41 to 0x30000 six times -> io_buffer_full=1 the cycle after the 6th write (8-deep, margin 2). Then tx_ready=1 -> bytes drain in order 0x41..., and io_buffer_full drops once 3 slots are free.
- RX read: drive rx_valid with 0x5A, then 0x5B; read 0x30000 three times -> 0x5A, 0x5B, 0x00 (third read on empty, no underflow).
- Halt: write 0x01 to 0x30004 -> halted=1 next cycle; read 0x30004 -> 0x01. Assert rst -> halted=0, mem_dout=0, tx_valid=0, and the RAM byte at 0x00010 still reads 0xAA.
- Simultaneous TX push and pop while full: fill 8 bytes, then write 0x77 with tx_ready=1 in the same cycle -> count stays 8, no overflow flag, 0x77 is the last byte drained.
